// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache miss sequencer.
package cache_pkg;

  // Miss service states, in the order a dirty miss walks through them.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WB_REQ     = 3'd1,
    WB_WAIT    = 3'd2,
    FETCH_REQ  = 3'd3,
    FETCH_WAIT = 3'd4,
    FILL       = 3'd5
  } missSeqState_t;

  // Memory request type as driven on memReqWrite.
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  // Number of byte-offset bits inside one cache block.
  function automatic int block_offset_bits(input int block_size);
    return $clog2(block_size);
  endfunction

endpackage

// File: rtl/miss_sequencer_if.sv
// Miss, memory-request and fill channels between the cache controller,
// the miss sequencer and main memory.
interface miss_sequencer_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_SIZE    = 32
);
  localparam int DATA_WIDTH = 8 * BLOCK_SIZE;

  logic                     missValid;
  logic                     missReady;
  logic [ADDRESS_WIDTH-1:0] missAddress;
  logic                     victimDirty;
  logic [ADDRESS_WIDTH-1:0] victimAddress;
  logic [DATA_WIDTH-1:0]    victimData;

  logic                     memReqValid;
  logic                     memReqReady;
  logic                     memReqWrite;
  logic [ADDRESS_WIDTH-1:0] memReqAddress;
  logic [DATA_WIDTH-1:0]    memWriteData;
  logic                     memRespValid;
  logic [DATA_WIDTH-1:0]    memRespData;

  logic                     fillValid;
  logic [ADDRESS_WIDTH-1:0] fillAddress;
  logic [DATA_WIDTH-1:0]    fillData;
  logic                     timeoutError;
  logic                     busy;

  // Sequencer side: serves misses, masters the memory channel.
  modport slave (
    input  missValid, missAddress, victimDirty, victimAddress, victimData,
    input  memReqReady, memRespValid, memRespData,
    output missReady, memReqValid, memReqWrite, memReqAddress, memWriteData,
    output fillValid, fillAddress, fillData, timeoutError, busy
  );

  // Environment side: cache controller plus main memory.
  modport master (
    output missValid, missAddress, victimDirty, victimAddress, victimData,
    output memReqReady, memRespValid, memRespData,
    input  missReady, memReqValid, memReqWrite, memReqAddress, memWriteData,
    input  fillValid, fillAddress, fillData, timeoutError, busy
  );

endinterface

// File: rtl/miss_sequencer.sv
// Services one cache miss at a time: optional victim write-back, block
// fetch, then a single-cycle fill back to the controller. All outputs are
// decodes of registered state.
//
// state      | meaning
// IDLE       | ready for a miss (held off for the cycle of a timeout pulse)
// WB_REQ     | write-back request of the dirty victim on the memory channel
// WB_WAIT    | waiting for the write-back acknowledge
// FETCH_REQ  | fetch request for the missing block
// FETCH_WAIT | waiting for fetched data
// FILL       | one-cycle fill pulse to the controller
module miss_sequencer
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int BLOCK_SIZE     = 32,
  parameter int COUNTER_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            reset_n,
  miss_sequencer_if.slave bus
);

  localparam int DATA_WIDTH        = 8 * BLOCK_SIZE;
  localparam int BLOCK_OFFSET_BITS = block_offset_bits(BLOCK_SIZE);
  localparam logic [ADDRESS_WIDTH-1:0] BLOCK_MASK =
    ~((ADDRESS_WIDTH'(1) << BLOCK_OFFSET_BITS) - ADDRESS_WIDTH'(1));
  // The abort is decided on the last wait cycle so that the error pulse
  // coincides with the counter reaching TIMEOUT_CYCLES.
  localparam logic [COUNTER_WIDTH-1:0] CNT_LIMIT = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX   = '1;

  missSeqState_t            state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                     timeout_q, timeout_d;
  logic [ADDRESS_WIDTH-1:0] miss_addr_q, miss_addr_d;
  logic                     victim_dirty_q, victim_dirty_d;
  logic [ADDRESS_WIDTH-1:0] victim_addr_q, victim_addr_d;
  logic [DATA_WIDTH-1:0]    victim_data_q, victim_data_d;
  logic [DATA_WIDTH-1:0]    fill_data_q, fill_data_d;
  logic                     miss_ready;

  assign miss_ready = (state_q == IDLE) && !timeout_q;
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + COUNTER_WIDTH'(1);

  // Next-state, wait counter and captured miss context.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    timeout_d      = 1'b0;
    miss_addr_d    = miss_addr_q;
    victim_dirty_d = victim_dirty_q;
    victim_addr_d  = victim_addr_q;
    victim_data_d  = victim_data_q;
    fill_data_d    = fill_data_q;
    case (state_q)
      IDLE: begin
        if (bus.missValid && miss_ready) begin
          miss_addr_d    = bus.missAddress & BLOCK_MASK;
          victim_dirty_d = bus.victimDirty;
          victim_addr_d  = bus.victimAddress & BLOCK_MASK;
          victim_data_d  = bus.victimData;
          state_d        = bus.victimDirty ? WB_REQ : FETCH_REQ;
        end
      end
      WB_REQ: begin
        if (bus.memReqReady) begin
          state_d = WB_WAIT;
          cnt_d   = '0;
        end
      end
      WB_WAIT: begin
        if (bus.memRespValid) begin
          state_d = FETCH_REQ;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q == CNT_LIMIT) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
          end
        end
      end
      FETCH_REQ: begin
        if (bus.memReqReady) begin
          state_d = FETCH_WAIT;
          cnt_d   = '0;
        end
      end
      FETCH_WAIT: begin
        if (bus.memRespValid) begin
          fill_data_d = bus.memRespData;
          state_d     = FILL;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q == CNT_LIMIT) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
          end
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything mid-transfer too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      timeout_q      <= 1'b0;
      miss_addr_q    <= '0;
      victim_dirty_q <= 1'b0;
      victim_addr_q  <= '0;
      victim_data_q  <= '0;
      fill_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      timeout_q      <= timeout_d;
      miss_addr_q    <= miss_addr_d;
      victim_dirty_q <= victim_dirty_d;
      victim_addr_q  <= victim_addr_d;
      victim_data_q  <= victim_data_d;
      fill_data_q    <= fill_data_d;
    end
  end

  assign bus.missReady     = miss_ready;
  assign bus.busy          = (state_q != IDLE);
  assign bus.memReqValid   = (state_q == WB_REQ) || (state_q == FETCH_REQ);
  assign bus.memReqWrite   = ((state_q == WB_REQ) && victim_dirty_q) ? REQ_WRITE : REQ_FETCH;
  assign bus.memReqAddress = (state_q == WB_REQ) ? victim_addr_q : miss_addr_q;
  assign bus.memWriteData  = victim_data_q;
  assign bus.fillValid     = (state_q == FILL);
  assign bus.fillAddress   = miss_addr_q;
  assign bus.fillData      = fill_data_q;
  assign bus.timeoutError  = timeout_q;

endmodule

// File: tb/tb_miss_sequencer.sv
// Self-checking bench for miss_sequencer: scoreboard of expected memory
// requests and fills, one task per scenario.
module tb_miss_sequencer;

  localparam int AW = 32;
  localparam int BS = 32;
  localparam int DW = 8 * BS;
  localparam int TO = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  miss_sequencer_if #(.ADDRESS_WIDTH(AW), .BLOCK_SIZE(BS)) bus ();

  miss_sequencer #(
    .ADDRESS_WIDTH(AW), .BLOCK_SIZE(BS), .COUNTER_WIDTH(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } fill_t;

  req_t  exp_req_q[$];
  fill_t exp_fill_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic logic [DW-1:0] pattern(input logic [31:0] seed);
    logic [DW-1:0] p;
    for (int i = 0; i < DW / 32; i++) p[i*32 +: 32] = seed + 32'(i);
    return p;
  endfunction

  // Drives one miss and acts as memory; compares requests and fills
  // against the scoreboard as they appear.
  task automatic run_miss(input logic [AW-1:0] addr, input logic dirty,
                          input logic [AW-1:0] vaddr, input logic [DW-1:0] vdata,
                          input logic [DW-1:0] rdata, input int ready_hold,
                          input int resp_delay, input bit stray,
                          output int fill_cyc, output int to_cyc,
                          output int req_cnt, output logic ready_at_end);
    int    cyc, stall, resp_at;
    logic  held;
    req_t  hold_v, exp, obs;
    fill_t fexp;
    bit    done;
    @(negedge clk);
    n_tests++;
    if (bus.missReady !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_ready_before_accept: got %b want 1", bus.missReady);
    end
    bus.missValid     = 1'b1;
    bus.missAddress   = addr;
    bus.victimDirty   = dirty;
    bus.victimAddress = vaddr;
    bus.victimData    = vdata;
    bus.memReqReady   = 1'b0;
    bus.memRespValid  = 1'b0;
    cyc = 0; stall = 0; resp_at = -1; held = 1'b0; done = 1'b0;
    fill_cyc = -1; to_cyc = -1; req_cnt = 0; ready_at_end = 1'b1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.missValid    = 1'b0;
      bus.victimDirty  = 1'b0;
      bus.memRespValid = (cyc == resp_at);
      bus.memRespData  = (cyc == resp_at) ? rdata : pattern($urandom());
      bus.memReqReady  = 1'b0;
      if (bus.fillValid === 1'b1) begin
        fill_cyc = cyc;
        ready_at_end = bus.missReady;
        done = 1'b1;
        n_tests++;
        if (exp_fill_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_fill: got addr %h, want no fill", bus.fillAddress);
        end else begin
          fexp = exp_fill_q.pop_front();
          if (bus.fillAddress !== fexp.addr || bus.fillData !== fexp.data) begin
            n_fail++;
            $display("FAIL fill_content: got %h/%h want %h/%h",
                     bus.fillAddress, bus.fillData, fexp.addr, fexp.data);
          end
        end
      end
      if (bus.timeoutError === 1'b1) begin
        to_cyc = cyc;
        ready_at_end = bus.missReady;
        done = 1'b1;
      end
      if (bus.memReqValid === 1'b1) begin
        obs = '{wr: bus.memReqWrite, addr: bus.memReqAddress, data: bus.memWriteData};
        if (stall < ready_hold) begin
          if (held) begin
            n_tests++;
            if (obs.wr !== hold_v.wr || obs.addr !== hold_v.addr || obs.data !== hold_v.data) begin
              n_fail++;
              $display("FAIL req_stable: got %b/%h want %b/%h", obs.wr, obs.addr, hold_v.wr, hold_v.addr);
            end
          end else begin
            hold_v = obs;
            held   = 1'b1;
          end
          stall++;
          if (stray) bus.memRespValid = 1'b1;
        end else begin
          bus.memReqReady = 1'b1;
          req_cnt++;
          n_tests++;
          if (exp_req_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_req: got %b/%h want no request", obs.wr, obs.addr);
          end else begin
            exp = exp_req_q.pop_front();
            if (obs.wr !== exp.wr || obs.addr !== exp.addr || (exp.wr && obs.data !== exp.data)) begin
              n_fail++;
              $display("FAIL req_content: got %b/%h/%h want %b/%h/%h",
                       obs.wr, obs.addr, obs.data, exp.wr, exp.addr, exp.data);
            end
          end
          stall   = 0;
          held    = 1'b0;
          resp_at = (resp_delay > 0) ? cyc + resp_delay : -1;
        end
      end
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL miss_completion: no fill or timeout within %0d cycles", cyc);
    end
    bus.memReqReady  = 1'b0;
    bus.memRespValid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.missValid = 1'b0; bus.missAddress = '0; bus.victimDirty = 1'b0;
    bus.victimAddress = '0; bus.victimData = '0; bus.memReqReady = 1'b0;
    bus.memRespValid = 1'b0; bus.memRespData = '0;
    #12;
    n_tests++;
    if (bus.memReqValid !== 1'b0 || bus.fillValid !== 1'b0 || bus.timeoutError !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req %b fill %b to %b busy %b want 0 0 0 0",
               bus.memReqValid, bus.fillValid, bus.timeoutError, bus.busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (bus.missReady !== 1'b1 || bus.memReqAddress !== '0 || bus.fillData !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got ready %b addr %h want 1 0", bus.missReady, bus.memReqAddress);
    end
  endtask

  task automatic test_clean_miss();
    int fc, tc, rc; logic rdy;
    exp_req_q.push_back('{wr: 1'b0, addr: 32'h0000_1220, data: '0});
    exp_fill_q.push_back('{addr: 32'h0000_1220, data: {BS{8'hA5}}});
    run_miss(32'h0000_1234, 1'b0, 32'h0, '0, {BS{8'hA5}}, 0, 1, 1'b0, fc, tc, rc, rdy);
    n_tests++;
    if (fc !== 3 || tc !== -1 || rc !== 1 || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_timing: got fill %0d to %0d reqs %0d ready %b want 3 -1 1 0", fc, tc, rc, rdy);
    end
  endtask

  task automatic test_dirty_miss();
    int fc, tc, rc; logic rdy;
    logic [DW-1:0] p, r;
    p = pattern(32'hC0DE_0000);
    r = pattern(32'h1111_0000);
    exp_req_q.push_back('{wr: 1'b1, addr: 32'h0000_8040, data: p});
    exp_req_q.push_back('{wr: 1'b0, addr: 32'h0000_5660, data: '0});
    exp_fill_q.push_back('{addr: 32'h0000_5660, data: r});
    run_miss(32'h0000_5678, 1'b1, 32'h0000_8040, p, r, 0, 1, 1'b0, fc, tc, rc, rdy);
    n_tests++;
    if (fc !== 5 || tc !== -1 || rc !== 2) begin
      n_fail++;
      $display("FAIL dirty_timing: got fill %0d to %0d reqs %0d want 5 -1 2", fc, tc, rc);
    end
  endtask

  task automatic test_back_to_back();
    int fc, tc, rc; logic rdy;
    logic [AW-1:0] a[2];
    logic [AW-1:0] e[2];
    a[0] = 32'hFFFF_FFFF; e[0] = 32'hFFFF_FFE0;
    a[1] = 32'h0000_001F; e[1] = 32'h0000_0000;
    for (int i = 0; i < 2; i++) begin
      exp_req_q.push_back('{wr: 1'b0, addr: e[i], data: '0});
      exp_fill_q.push_back('{addr: e[i], data: pattern(32'h2000_0000 + 32'(i))});
      run_miss(a[i], 1'b0, 32'h0, '0, pattern(32'h2000_0000 + 32'(i)), 0, 1, 1'b0, fc, tc, rc, rdy);
      n_tests++;
      if (fc !== 3 || rc !== 1) begin
        n_fail++;
        $display("FAIL b2b_timing[%0d]: got fill %0d reqs %0d want 3 1", i, fc, rc);
      end
    end
  endtask

  task automatic test_req_hold();
    int fc, tc, rc; logic rdy;
    exp_req_q.push_back('{wr: 1'b0, addr: 32'h0001_0040, data: '0});
    exp_fill_q.push_back('{addr: 32'h0001_0040, data: pattern(32'h3300_0000)});
    run_miss(32'h0001_0044, 1'b0, 32'h0, '0, pattern(32'h3300_0000), 4, 1, 1'b0, fc, tc, rc, rdy);
    n_tests++;
    if (fc !== 7 || rc !== 1) begin
      n_fail++;
      $display("FAIL hold_timing: got fill %0d reqs %0d want 7 1", fc, rc);
    end
  endtask

  task automatic test_stray_resp();
    int fc, tc, rc; logic rdy;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.memRespValid = 1'b1;
      bus.memRespData  = pattern(32'hBAD0_0000);
    end
    @(negedge clk);
    bus.memRespValid = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.fillValid !== 1'b0 || bus.missReady !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_idle: got busy %b fill %b ready %b want 0 0 1", bus.busy, bus.fillValid, bus.missReady);
    end
    exp_req_q.push_back('{wr: 1'b0, addr: 32'h0000_0A00, data: '0});
    exp_fill_q.push_back('{addr: 32'h0000_0A00, data: pattern(32'h4400_0000)});
    run_miss(32'h0000_0A10, 1'b0, 32'h0, '0, pattern(32'h4400_0000), 2, 1, 1'b1, fc, tc, rc, rdy);
    n_tests++;
    if (fc !== 5 || rc !== 1 || tc !== -1) begin
      n_fail++;
      $display("FAIL stray_fetch_req: got fill %0d reqs %0d to %0d want 5 1 -1", fc, rc, tc);
    end
  endtask

  task automatic test_timeout();
    int fc, tc, rc; logic rdy;
    exp_req_q.push_back('{wr: 1'b0, addr: 32'h0000_7700, data: '0});
    run_miss(32'h0000_7708, 1'b0, 32'h0, '0, '0, 0, 0, 1'b0, fc, tc, rc, rdy);
    n_tests++;
    if (tc !== 12 || fc !== -1 || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse: got to %0d fill %0d ready %b want 12 -1 0", tc, fc, rdy);
    end
    @(negedge clk);
    n_tests++;
    if (bus.missReady !== 1'b1 || bus.timeoutError !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_after: got ready %b to %b busy %b want 1 0 0", bus.missReady, bus.timeoutError, bus.busy);
    end
  endtask

  task automatic test_resp_at_limit();
    int fc, tc, rc; logic rdy;
    exp_req_q.push_back('{wr: 1'b0, addr: 32'h0000_9900, data: '0});
    exp_fill_q.push_back('{addr: 32'h0000_9900, data: pattern(32'h5500_0000)});
    run_miss(32'h0000_9901, 1'b0, 32'h0, '0, pattern(32'h5500_0000), 0, 10, 1'b0, fc, tc, rc, rdy);
    n_tests++;
    if (fc !== 12 || tc !== -1) begin
      n_fail++;
      $display("FAIL resp_at_limit: got fill %0d to %0d want 12 -1", fc, tc);
    end
  endtask

  task automatic test_reset_mid();
    int fc, tc, rc; logic rdy;
    @(negedge clk);
    bus.missValid = 1'b1; bus.missAddress = 32'h0000_6000; bus.victimDirty = 1'b1;
    bus.victimAddress = 32'h0000_8040; bus.victimData = pattern(32'h6600_0000);
    bus.memReqReady = 1'b1;
    @(negedge clk);
    bus.missValid = 1'b0;
    n_tests++;
    if (bus.memReqValid !== 1'b1 || bus.memReqWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_wbreq: got valid %b write %b want 1 1", bus.memReqValid, bus.memReqWrite);
    end
    @(negedge clk);
    bus.memReqReady = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.memReqValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_wbwait: got busy %b valid %b want 1 0", bus.busy, bus.memReqValid);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.memReqValid !== 1'b0 || bus.fillValid !== 1'b0 ||
        bus.timeoutError !== 1'b0 || bus.memWriteData !== '0 || bus.memReqAddress !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got busy %b valid %b fill %b to %b addr %h want 0 0 0 0 0",
               bus.busy, bus.memReqValid, bus.fillValid, bus.timeoutError, bus.memReqAddress);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_req_q.push_back('{wr: 1'b0, addr: 32'h0000_6020, data: '0});
    exp_fill_q.push_back('{addr: 32'h0000_6020, data: pattern(32'h7700_0000)});
    run_miss(32'h0000_603C, 1'b0, 32'h0, '0, pattern(32'h7700_0000), 0, 1, 1'b0, fc, tc, rc, rdy);
    n_tests++;
    if (fc !== 3 || rc !== 1) begin
      n_fail++;
      $display("FAIL reset_mid_recover: got fill %0d reqs %0d want 3 1", fc, rc);
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_back_to_back();
    test_req_hold();
    test_stray_resp();
    test_timeout();
    test_resp_at_limit();
    test_reset_mid();
    n_tests++;
    if (exp_req_q.size() != 0 || exp_fill_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d reqs %0d fills left want 0 0", exp_req_q.size(), exp_fill_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/miss_sequencer.md
# miss_sequencer

Sequences one cache-miss service at a time between the cache controller and main memory. On a miss it writes back the dirty victim block first (if any), then fetches the requested block, and returns it to the controller as a one-cycle fill. It sits on the memory side of the controller and drives the fetch-address, write-back-address and write-back-data paths through a single valid/ready memory request channel.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- BLOCK_SIZE, 32, cache block size in bytes (power of two, ≥4)
- COUNTER_WIDTH, 8, width of response-wait counter
- TIMEOUT_CYCLES, 255, response-wait limit in cycles (1..2^COUNTER_WIDTH-1)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- missValid  in  1  controller presents a miss
- missReady  out  1  sequencer can accept a miss
- missAddress  in  ADDRESS_WIDTH  requested address (any byte in block)
- victimDirty  in  1  victim line needs write-back
- victimAddress  in  ADDRESS_WIDTH  victim block address
- victimData  in  8*BLOCK_SIZE  victim block contents
- memReqValid  out  1  memory request pending
- memReqReady  in  1  memory accepts request
- memReqWrite  out  1  1 = write-back, 0 = fetch
- memReqAddress  out  ADDRESS_WIDTH  block-aligned request address
- memWriteData  out  8*BLOCK_SIZE  write-back data
- memRespValid  in  1  read data valid / write acknowledged
- memRespData  in  8*BLOCK_SIZE  fetched block
- fillValid  out  1  one-cycle fill pulse to controller
- fillAddress  out  ADDRESS_WIDTH  block-aligned fill address
- fillData  out  8*BLOCK_SIZE  fetched block
- timeoutError  out  1  one-cycle pulse, miss aborted
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, WB_REQ, WB_WAIT, FETCH_REQ, FETCH_WAIT, FILL.
- IDLE: missReady=1. On missValid&&missReady, register missAddress, victimDirty, victimAddress, victimData; go WB_REQ if victimDirty else FETCH_REQ.
- Addresses: low log2(BLOCK_SIZE) bits forced to 0 on memReqAddress and fillAddress.
- WB_REQ: memReqValid=1, memReqWrite=1, address/data = registered victim; on memReqReady → WB_WAIT.
- WB_WAIT: on memRespValid → FETCH_REQ (data ignored).
- FETCH_REQ: memReqValid=1, memReqWrite=0, address = registered miss; on memReqReady → FETCH_WAIT.
- FETCH_WAIT: on memRespValid register memRespData → FILL.
- FILL: fillValid=1 for exactly one cycle → IDLE.
- memReqValid, once raised, holds with stable address/data/write until memReqReady.
- memRespValid outside *_WAIT states is ignored.
- Wait counter: cleared on entering either WAIT state, increments each WAIT cycle without memRespValid, saturates. When it equals TIMEOUT_CYCLES without response: timeoutError=1 for one cycle, return to IDLE, no fill. memRespValid in the same cycle as the limit wins (normal progress).
- Reset (any time, including mid-transfer): state IDLE, counter 0, all registered data 0; memReqValid, fillValid, timeoutError, busy = 0; missReady = 1 after reset deasserts.

## Timing
- Clean miss, memReqReady=1 and response next cycle: accept at cycle 0, FETCH_REQ 1, FETCH_WAIT 2 (resp), FILL 3 → fillValid at cycle 3, missReady again at cycle 4.
- Dirty miss adds 2 cycles minimum (WB_REQ, WB_WAIT): fillValid at cycle 5.
- All outputs registered-state decodes; no combinational path from mem* inputs to mem* outputs.
- Next miss accepted no earlier than the cycle after FILL or timeout.

## Structure
- Shared package cache_pkg: missSeqState_t enum, BLOCK_OFFSET_BITS = $clog2(BLOCK_SIZE) helper, request-type constants.
- No sub-module required; the wait counter stays inline.

## Test plan
- Clean miss, missAddress=0x0000_1234, memReqReady=1, resp 1 cycle later with data 0xA5..A5 → one fetch req at 0x0000_1220, fillValid at cycle 3 with fillAddress 0x0000_1220, fillData 0xA5..A5.
- Dirty miss, victimAddress=0x0000_8040, victimData pattern P → write req (memReqWrite=1, 0x0000_8040, P) precedes fetch req; fillValid at cycle 5.
- memReqReady low 4 cycles in FETCH_REQ → memReqValid, address stable all 4 cycles; single request accepted.
- No response, TIMEOUT_CYCLES=10 → timeoutError pulse 10 cycles after entering FETCH_WAIT, no fillValid, missReady=1 next cycle.
- reset_n low during WB_WAIT → all outputs return to reset values immediately; later miss completes normally.
- Stray memRespValid in IDLE and FETCH_REQ → ignored, no state change, no fill.
